if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Instruction buffer that sits between the fetch stage and decode.
- Captures each completed fetch (instruction, incremented PC, fetch error) into a small FIFO and presents the oldest entry to decode.
- Back-pressures fetch when the FIFO is full or a halt has been captured.
- Discards all buffered instructions on a branch/jump redirect.

Parameters:
DEPTH, 2, number of FIFO entries; legal values 2..8.
NOP_INSTR, 16'h0800, instruction word presented to decode when the queue is empty.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset; one clock; reset is synchronous and active-low
f_instr  input  16  instruction word from fetch
f_pc_incr  input  16  PC+2 (or PC for halt) from fetch
f_valid  input  1  fetch completed an access this cycle
f_err  input  1  fetch reported error (misaligned PC or memory error)
flush  input  1  branch/jump taken; discard all queued entries
d_stall  input  1  decode cannot consume the head entry this cycle
f_stall  output  1  fetch must hold its PC (queue full or halt captured)
d_instr  output  16  head instruction, NOP_INSTR when empty
d_pc_incr  output  16  head PC+2, 16'h0000 when empty
d_err  output  1  head entry error flag, 0 when empty
d_valid  output  1  head entry present
count  output  clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: DEPTH entries of {instr[15:0], pc_incr[15:0], err}, circular buffer with head and tail pointers of width clog2(DEPTH). Pointers wrap from DEPTH-1 to 0.
- Reset (rst==0 at a rising edge):
  - count=0, head=tail=0, halt_seen=0.
  - Outputs: d_valid=0, d_instr=NOP_INSTR, d_pc_incr=0, d_err=0, f_stall=0.
  - Reset overrides every other input, including mid-operation with a full queue.
- full = (count==DEPTH). empty = (count==0).
- Enqueue condition: f_valid & ~full & ~halt_seen & ~flush. Writes the entry at tail, then tail++.
- Dequeue condition: ~empty & ~d_stall & ~flush. Head advances, head++.
- Enqueue and dequeue in the same cycle: both occur and count is unchanged. Allowed at any non-full occupancy, including count==1 (no bypass).
- Enqueue when full is never accepted, even if a dequeue occurs the same cycle. Fetch is already stalled by f_stall.
- count update per cycle: count + enq - deq.
- Latency: an instruction enqueued at edge N is visible on d_* after edge N. There is no combinational path from f_* to d_*.
- Head outputs:
  - d_valid = ~empty.
  - d_instr/d_pc_incr/d_err are driven combinationally from the head entry when ~empty, otherwise NOP_INSTR/0/0.
- Halt capture:
  - When an enqueued instr has [15:11]==5'b00000, halt_seen is set at that edge.
  - While halt_seen=1, no further enqueues occur. Already-queued entries still drain normally.
- f_stall = full | halt_seen. It depends only on registered state (no combinational path from inputs).
- Flush:
  - At the edge, count=0, head=tail=0, halt_seen=0.
  - The incoming fetch in the flush cycle is dropped. Any dequeue in that cycle is suppressed.
  - Flush takes priority over enq/deq. Flush while empty is harmless.
- f_valid with f_err=1 is enqueued like any entry. The error is carried to d_err and does not alter queue control.
- d_stall while empty has no effect.

Test Plan:
- Reset then idle: hold rst=0 two cycles, release -> d_valid=0, d_instr=16'h0800, count=0, f_stall=0.
- Fill: d_stall=1, f_valid=1 with instr 16'h4001 (pc_incr 16'h0002), then 16'h4002 (16'h0004) -> count=2, f_stall=1. A third word 16'h4003 is not enqueued. Release d_stall -> decode sees 4001, 4002 in order, then NOP with d_valid=0.
- Streaming: f_valid=1 and d_stall=0 every cycle for 20 words -> count stays 1 after the first edge, each word appears on d_instr exactly one cycle after it is presented, and the pointers wrap without loss or reorder.
- Flush: queue holds 2 entries, flush=1 with f_valid=1 (instr 16'h6000) -> next cycle count=0, d_valid=0, and 16'h6000 is never presented.
- Halt: enqueue 16'h0000 -> f_stall=1 next cycle. Further f_valid words are ignored, the halt drains to decode, and f_stall stays 1 until flush or reset.
- Error and mid-operation reset: enqueue with f_err=1 -> d_err=1 on that entry only. Then assert rst=0 with count=2 -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode instruction buffer.
// Completed fetches go into a small circular FIFO, and the oldest entry is
// shown to decode. Fetch is held off while the FIFO is full or after a halt
// has been captured. A branch/jump redirect empties the FIFO.
module if_id_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                f_instr,
    input  logic [15:0]                f_pc_incr,
    input  logic                       f_valid,
    input  logic                       f_err,
    input  logic                       flush,
    input  logic                       d_stall,
    output logic                       f_stall,
    output logic [15:0]                d_instr,
    output logic [15:0]                d_pc_incr,
    output logic                       d_err,
    output logic                       d_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage. It holds data only and is never reset. Occupancy
    // (count) decides which entries are live.
    logic [15:0] instr_mem [DEPTH];
    logic [15:0] pc_mem    [DEPTH];
    logic        err_mem   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             halt_seen;
    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;

    // Pointers wrap at DEPTH-1. DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    // A halt has opcode bits [15:11] all zero.
    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[15:11] == 5'b00000);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full queue refuses a write even when a read happens in the same
    // cycle. There is no write-through bypass.
    assign enq = f_valid & ~full & ~halt_seen & ~flush;
    assign deq = ~empty & ~d_stall & ~flush;

    // f_stall is built only from registered state, so fetch sees no
    // combinational path from any input.
    assign f_stall = full | halt_seen;

    // Head presentation: an empty queue shows a NOP with zeroed side fields.
    always_comb begin
        d_valid   = ~empty;
        d_instr   = NOP_INSTR;
        d_pc_incr = 16'h0000;
        d_err     = 1'b0;
        if (!empty) begin
            d_instr   = instr_mem[head];
            d_pc_incr = pc_mem[head];
            d_err     = err_mem[head];
        end
    end

    // Control state: pointers, occupancy and halt capture. Flush beats enq/deq.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            halt_seen <= 1'b0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            halt_seen <= 1'b0;
        end else begin
            if (enq) begin
                tail <= next_ptr(tail);
                if (is_halt(f_instr))
                    halt_seen <= 1'b1;
            end
            if (deq)
                head <= next_ptr(head);
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Entry write at the tail slot.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[tail] <= f_instr;
            pc_mem[tail]    <= f_pc_incr;
            err_mem[tail]   <= f_err;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed bench for if_id_queue. A queue-based model
// predicts the decode-side view every cycle, and literal expectations pin
// key points of each scenario.
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic [15:0]      f_instr;
    logic [15:0]      f_pc_incr;
    logic             f_valid;
    logic             f_err;
    logic             flush;
    logic             d_stall;
    logic             f_stall;
    logic [15:0]      d_instr;
    logic [15:0]      d_pc_incr;
    logic             d_err;
    logic             d_valid;
    logic [CNT_W-1:0] count;

    if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(16'h0800)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_instr   (f_instr),
        .f_pc_incr (f_pc_incr),
        .f_valid   (f_valid),
        .f_err     (f_err),
        .flush     (flush),
        .d_stall   (d_stall),
        .f_stall   (f_stall),
        .d_instr   (d_instr),
        .d_pc_incr (d_pc_incr),
        .d_err     (d_err),
        .d_valid   (d_valid),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        err;
    } ent_t;

    ent_t mq[$];
    bit   mhalt;
    int   n_cmp;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour for one rising edge, written from the queue rules.
    task automatic model_edge();
        bit   do_enq;
        bit   do_deq;
        ent_t e;
        if (!rst || flush) begin
            mq.delete();
            mhalt = 0;
        end else begin
            do_enq = f_valid && (mq.size() < DEPTH) && !mhalt;
            do_deq = (mq.size() > 0) && !d_stall;
            if (do_deq) void'(mq.pop_front());
            if (do_enq) begin
                e.instr = f_instr;
                e.pc    = f_pc_incr;
                e.err   = f_err;
                mq.push_back(e);
                if (f_instr[15:11] == 5'b00000) mhalt = 1;
            end
        end
    endtask

    task automatic compare_model();
        logic [15:0] ei;
        logic [15:0] ep;
        logic        ee;
        ei = 16'h0800;
        ep = 16'h0000;
        ee = 1'b0;
        if (mq.size() > 0) begin
            ei = mq[0].instr;
            ep = mq[0].pc;
            ee = mq[0].err;
        end
        chk("m_valid", 32'(d_valid), 32'(mq.size() > 0));
        chk("m_instr", 32'(d_instr), 32'(ei));
        chk("m_pc", 32'(d_pc_incr), 32'(ep));
        chk("m_err", 32'(d_err), 32'(ee));
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_fstall", 32'(f_stall), 32'((mq.size() == DEPTH) || mhalt));
    endtask

    // One clock: inputs already set at the falling edge, the model follows
    // the rising edge, and outputs are compared at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic fetch(input logic v, input logic [15:0] i, input logic [15:0] p, input logic e);
        f_valid   = v;
        f_instr   = i;
        f_pc_incr = p;
        f_err     = e;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        mhalt  = 0;
        rst     = 1'b0;
        flush   = 1'b0;
        d_stall = 1'b0;
        fetch(1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);

        // Reset then idle
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_valid", 32'(d_valid), 32'd0);
        chk("rst_instr", 32'(d_instr), 32'h0800);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_fstall", 32'(f_stall), 32'd0);

        // Fill under decode stall, then drain in order
        d_stall = 1'b1;
        fetch(1'b1, 16'h4001, 16'h0002, 1'b0);
        cycle();
        chk("fill1_instr", 32'(d_instr), 32'h4001);
        fetch(1'b1, 16'h4002, 16'h0004, 1'b0);
        cycle();
        chk("fill2_count", 32'(count), 32'd2);
        chk("fill2_fstall", 32'(f_stall), 32'd1);
        fetch(1'b1, 16'h4003, 16'h0006, 1'b0);
        cycle();
        chk("fill3_count", 32'(count), 32'd2);
        d_stall = 1'b0;
        fetch(1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        chk("drain1_instr", 32'(d_instr), 32'h4002);
        chk("drain1_pc", 32'(d_pc_incr), 32'h0004);
        cycle();
        chk("drain2_valid", 32'(d_valid), 32'd0);
        chk("drain2_instr", 32'(d_instr), 32'h0800);

        // Streaming: one word per cycle through a one-deep occupancy
        for (int i = 0; i < 20; i++) begin
            fetch(1'b1, 16'h5000 + 16'(i), 16'(2 * i + 2), 1'b0);
            cycle();
            chk("stream_instr", 32'(d_instr), 32'h5000 + 32'(i));
            chk("stream_count", 32'(count), 32'd1);
        end
        fetch(1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();

        // Flush with two queued entries and a fetch arriving in the flush cycle
        d_stall = 1'b1;
        fetch(1'b1, 16'h7001, 16'h0100, 1'b0);
        cycle();
        fetch(1'b1, 16'h7002, 16'h0102, 1'b0);
        cycle();
        flush = 1'b1;
        fetch(1'b1, 16'h6000, 16'h0104, 1'b0);
        cycle();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(d_valid), 32'd0);
        flush   = 1'b0;
        d_stall = 1'b0;
        fetch(1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        chk("flush_nop", 32'(d_instr), 32'h0800);

        // Halt capture blocks further fetches until a flush
        d_stall = 1'b1;
        fetch(1'b1, 16'h0000, 16'h0010, 1'b0);
        cycle();
        chk("halt_fstall", 32'(f_stall), 32'd1);
        fetch(1'b1, 16'h4444, 16'h0012, 1'b0);
        cycle();
        chk("halt_block", 32'(count), 32'd1);
        d_stall = 1'b0;
        cycle();
        chk("halt_drained", 32'(count), 32'd0);
        cycle();
        chk("halt_hold", 32'(f_stall), 32'd1);
        flush = 1'b1;
        fetch(1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        chk("halt_clear", 32'(f_stall), 32'd0);
        flush = 1'b0;

        // Error flag follows its own entry only
        d_stall = 1'b1;
        fetch(1'b1, 16'h4100, 16'h0020, 1'b1);
        cycle();
        chk("err_head", 32'(d_err), 32'd1);
        fetch(1'b1, 16'h4101, 16'h0022, 1'b0);
        cycle();
        d_stall = 1'b0;
        fetch(1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();
        chk("err_next", 32'(d_err), 32'd0);
        chk("err_next_instr", 32'(d_instr), 32'h4101);

        // Reset with a full queue
        d_stall = 1'b1;
        fetch(1'b1, 16'h4102, 16'h0024, 1'b1);
        cycle();
        chk("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b0;
        fetch(1'b1, 16'h4103, 16'h0026, 1'b0);
        cycle();
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_valid", 32'(d_valid), 32'd0);
        chk("mrst_instr", 32'(d_instr), 32'h0800);
        chk("mrst_pc", 32'(d_pc_incr), 32'h0000);
        chk("mrst_err", 32'(d_err), 32'd0);
        chk("mrst_fstall", 32'(f_stall), 32'd0);
        rst     = 1'b1;
        d_stall = 1'b0;
        fetch(1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
